// File: rtl/leaf_quad_bft_concentrator.sv
// leaf_quad_bft_concentrator: per-leaf up FIFOs merged round-robin onto one upstream link,
// plus a registered address-routed down path to the four leaves.
module leaf_quad_bft_concentrator #(
    parameter int PKT_W      = 49,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_LSB   = 43,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PKT_W-1:0] leaf_din_0,
    input  logic [PKT_W-1:0] leaf_din_1,
    input  logic [PKT_W-1:0] leaf_din_2,
    input  logic [PKT_W-1:0] leaf_din_3,
    output logic [PKT_W-1:0] leaf_dout_0,
    output logic [PKT_W-1:0] leaf_dout_1,
    output logic [PKT_W-1:0] leaf_dout_2,
    output logic [PKT_W-1:0] leaf_dout_3,
    output logic [3:0]       leaf_resend,
    output logic [PKT_W-1:0] up_dout,
    input  logic             up_resend,
    input  logic [PKT_W-1:0] up_din,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [PKT_W-1:0] din [4];
    logic [PKT_W-1:0] dn [4];
    logic [PKT_W-1:0] mem [4][FIFO_DEPTH];
    logic [AW:0]      wp [4];
    logic [AW:0]      rp [4];
    logic [AW:0]      occ [4];
    logic [3:0]       full, empty, pop, push, drop;
    logic [1:0]       rr, grant, idx;
    logic             found, hold;
    logic [2:0]       nd;
    logic [CNT_W:0]   sum;

    assign din[0] = leaf_din_0;
    assign din[1] = leaf_din_1;
    assign din[2] = leaf_din_2;
    assign din[3] = leaf_din_3;
    assign leaf_dout_0 = dn[0];
    assign leaf_dout_1 = dn[1];
    assign leaf_dout_2 = dn[2];
    assign leaf_dout_3 = dn[3];

    assign hold = up_dout[PKT_W-1] & up_resend;

    // occupancy reaches exactly FIFO_DEPTH only when full, so its MSB is the full flag
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            occ[i]   = wp[i] - rp[i];
            full[i]  = occ[i][AW];
            empty[i] = occ[i] == '0;
        end
    end

    always_comb begin
        found = 1'b0;
        grant = rr;
        idx   = rr;
        for (int k = 0; k < 4; k++) begin
            idx = rr + 2'(k);
            if (!found && !empty[idx]) begin
                found = 1'b1;
                grant = idx;
            end
        end
    end

    always_comb begin
        pop = (found && !hold) ? 4'b1 << grant : 4'b0;
        for (int i = 0; i < 4; i++) begin
            push[i] = din[i][PKT_W-1] & (~full[i] | pop[i]);
            drop[i] = din[i][PKT_W-1] & full[i] & ~pop[i];
        end
        nd  = {2'b0, drop[0]} + {2'b0, drop[1]} + {2'b0, drop[2]} + {2'b0, drop[3]};
        sum = {1'b0, drop_cnt} + (CNT_W+1)'(nd);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (push[i]) mem[i][wp[i][AW-1:0]] <= din[i];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                wp[i] <= '0;
                rp[i] <= '0;
                dn[i] <= '0;
            end
            rr          <= '0;
            up_dout     <= '0;
            leaf_resend <= '0;
            drop_cnt    <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push[i]) wp[i] <= wp[i] + 1'b1;
                if (pop[i]) rp[i] <= rp[i] + 1'b1;
                dn[i] <= (up_din[PKT_W-1] && up_din[ADDR_LSB+1:ADDR_LSB] == 2'(i)) ? up_din : '0;
            end
            if (!hold) begin
                up_dout <= found ? mem[grant][rp[grant][AW-1:0]] : '0;
                if (found) rr <= grant + 2'd1;
            end
            leaf_resend <= drop;
            drop_cnt    <= sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_leaf_quad_bft_concentrator.sv
// tb_leaf_quad_bft_concentrator: queue-based reference model with per-cycle compare plus literal checks.
module tb_leaf_quad_bft_concentrator;
    localparam int W = 49;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] din [4];
    logic [W-1:0] dout [4];
    logic [W-1:0] up_din, up_dout;
    logic         up_resend;
    logic [3:0]   leaf_resend;
    logic [15:0]  drop_cnt;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 0;

    leaf_quad_bft_concentrator dut (
        .clk(clk), .reset(reset),
        .leaf_din_0(din[0]), .leaf_din_1(din[1]), .leaf_din_2(din[2]), .leaf_din_3(din[3]),
        .leaf_dout_0(dout[0]), .leaf_dout_1(dout[1]), .leaf_dout_2(dout[2]), .leaf_dout_3(dout[3]),
        .leaf_resend(leaf_resend), .up_dout(up_dout), .up_resend(up_resend),
        .up_din(up_din), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: plain queues, round-robin search, saturating counter
    logic [W-1:0] mq [4][$];
    logic [W-1:0] m_up;
    logic [W-1:0] m_dn [4];
    logic [3:0]   m_rs, fullv, dr;
    logic [15:0]  m_cnt;
    int           m_rr, g, nd;
    bit           hold_m;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                m_dn[i] = '0;
            end
            m_up = '0; m_rs = '0; m_cnt = '0; m_rr = 0;
        end else begin
            hold_m = m_up[W-1] && up_resend;
            for (int i = 0; i < 4; i++) fullv[i] = mq[i].size() == 4;
            g = -1;
            if (!hold_m) begin
                for (int k = 0; k < 4; k++)
                    if (g < 0 && mq[(m_rr + k) % 4].size() > 0) g = (m_rr + k) % 4;
                if (g >= 0) begin
                    m_up = mq[g].pop_front();
                    m_rr = (g + 1) % 4;
                end else m_up = '0;
            end
            dr = '0;
            for (int i = 0; i < 4; i++)
                if (din[i][W-1]) begin
                    if (fullv[i] && g != i) dr[i] = 1'b1;
                    else mq[i].push_back(din[i]);
                end
            nd = $countones(dr);
            m_cnt = (int'(m_cnt) + nd > 65535) ? 16'hFFFF : 16'(int'(m_cnt) + nd);
            m_rs = dr;
            for (int i = 0; i < 4; i++)
                m_dn[i] = (up_din[W-1] && int'(up_din[44:43]) == i) ? up_din : '0;
        end
    end

    always @(negedge clk) begin
        if (!reset && run_cmp) begin
            chk("up_dout", up_dout, m_up);
            chk("leaf_resend", leaf_resend, m_rs);
            chk("drop_cnt", drop_cnt, m_cnt);
            for (int i = 0; i < 4; i++) chk($sformatf("leaf_dout_%0d", i), dout[i], m_dn[i]);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) din[i] = '0;
        up_din = '0;
        up_resend = 1'b0;
    endtask

    task automatic rst_pulse();
        #2 reset = 1'b1;
        #2 reset = 1'b0;
        tick();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_up_dout"}, up_dout, '0);
        chk({tag, "_resend"}, leaf_resend, '0);
        chk({tag, "_drop_cnt"}, drop_cnt, '0);
        for (int i = 0; i < 4; i++) chk($sformatf("%s_dout_%0d", tag, i), dout[i], '0);
    endtask

    logic [W-1:0] pa, pb, px;
    int pulses;

    initial begin
        idle();
        #7 check_zero("reset");
        #5 reset = 1'b0;
        tick();
        run_cmp = 1;

        // single packet latency
        din[2] = 49'h1_0000_0000_00AB;
        tick();
        din[2] = '0;
        chk("t1_not_early", up_dout, '0);
        tick();
        chk("t1_latency", up_dout, 49'h1_0000_0000_00AB);
        chk("t1_drop_cnt", drop_cnt, 16'd0);
        tick();

        // all leaves saturating the up link
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < 4; i++) din[i] = {1'b1, 16'($urandom), 32'($urandom)};
            up_din = {1'($urandom), 16'($urandom), 32'($urandom)};
            tick();
            pulses += $countones(leaf_resend);
        end
        chk("t2_drops_seen", pulses > 0, 1);
        chk("t2_cnt_eq_pulses", drop_cnt, 16'(pulses));
        idle();
        repeat (24) tick();

        // hold on up_resend
        rst_pulse();
        pa = 49'h1_AAAA_0000_0001;
        pb = 49'h1_BBBB_0000_0002;
        din[0] = pa; din[1] = pb;
        tick();
        idle();
        tick();
        chk("t3_first", up_dout, pa);
        up_resend = 1'b1;
        repeat (3) begin
            tick();
            chk("t3_hold", up_dout, pa);
        end
        up_resend = 1'b0;
        tick();
        chk("t3_next_grant", up_dout, pb);
        tick();
        chk("t3_empty", up_dout, '0);

        // down path routing
        for (int s = 0; s < 4; s++) begin
            px = {1'b1, 3'b0, 2'(s), 43'h123 + 43'(s)};
            up_din = px;
            tick();
            for (int j = 0; j < 4; j++)
                chk($sformatf("t4_sel%0d_dout%0d", s, j), dout[j], j == s ? px : '0);
        end
        up_din = {1'b0, 48'hFFFF_FFFF_FFFF};
        tick();
        for (int j = 0; j < 4; j++) chk($sformatf("t4_invalid_dout%0d", j), dout[j], '0);
        idle();

        // full FIFO popped while a new packet arrives
        rst_pulse();
        din[1] = {1'b1, 48'h500};
        tick();
        din[1] = '0;
        tick();
        chk("t5_x0", up_dout, {1'b1, 48'h500});
        up_resend = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            din[1] = {1'b1, 48'h500 + 48'(k)};
            tick();
        end
        din[1] = {1'b1, 48'h505};
        up_resend = 1'b0;
        tick();
        chk("t5_no_resend", leaf_resend, 4'b0);
        chk("t5_cnt_same", drop_cnt, 16'd0);
        chk("t5_x1", up_dout, {1'b1, 48'h501});
        idle();
        repeat (8) tick();

        // async reset mid-traffic, then first grant and saturation
        for (int c = 0; c < 40; c++) begin
            for (int i = 0; i < 4; i++) din[i] = {1'($urandom), 16'($urandom), 32'($urandom)};
            up_din = {1'($urandom), 16'($urandom), 32'($urandom)};
            up_resend = 1'($urandom);
            tick();
        end
        #2 reset = 1'b1;
        #1 check_zero("t6_async");
        idle();
        tick();
        reset = 1'b0;
        pa = 49'h1_2222_0000_0022;
        pb = 49'h1_3333_0000_0033;
        din[2] = pa; din[3] = pb;
        tick();
        idle();
        tick();
        chk("t6_first_grant", up_dout, pa);
        tick();
        chk("t6_second_grant", up_dout, pb);
        up_resend = 1'b1;
        for (int c = 0; c < 16500; c++) begin
            for (int i = 0; i < 4; i++) din[i] = {1'b1, 16'(c), 32'(i)};
            tick();
        end
        chk("t6_saturated", drop_cnt, 16'hFFFF);
        chk("t6_resend_all", leaf_resend, 4'hF);
        idle();
        tick();
        run_cmp = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
